// File: rtl/muldiv_seq.sv
// muldiv_seq: 34-cycle iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MULDIV_DIVZ_EN: divide by zero skips RUN and pulses divz instead of running.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             divz
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_mc;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_sgn_q, r_sgn_r, r_z, r_done;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_go, w_signed, w_zero, w_ge;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_sum, w_up, w_dif;
    logic [2*WIDTH-1:0] w_mul, w_div, w_res;

    assign w_go     = (r_state == IDLE) & start & ~cancel;
    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed & a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_signed & b[WIDTH-1]) ? -b : b;

    // Multiply: conditional add into the upper half, carry kept, then shift right.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mc};
    assign w_mul = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide: w_up is the remainder after the left shift, one bit wider than HI.
    assign w_up  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge  = w_up >= {1'b0, r_mc};
    assign w_dif = w_up - {1'b0, r_mc};
    assign w_div = {w_ge ? w_dif[WIDTH-1:0] : w_up[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};

    assign w_res = r_op[1]
        ? {r_sgn_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH],
           r_sgn_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]}
        : (r_sgn_q ? -r_acc : r_acc);

`ifdef MULDIV_DIVZ_EN
    logic r_divz;
    assign w_zero = op[1] & ~|b;
    assign divz   = r_divz;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_divz <= 1'b0;
        else
            r_divz <= (r_state == FIX) & r_z & ~cancel;
    end
`else
    assign w_zero = 1'b0;
    assign divz   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? (w_zero ? FIX : RUN) : IDLE;
            RUN:     w_next = cancel ? IDLE : (r_cnt == CW'(WIDTH - 1)) ? FIX : RUN;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_mc    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sgn_q <= 1'b0;
            r_sgn_r <= 1'b0;
            r_z     <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_op    <= op;
                        r_mc    <= op[1] ? w_abs_b : w_abs_a;
                        r_acc   <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
                        r_cnt   <= '0;
                        r_sgn_q <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sgn_r <= w_signed & op[1] & a[WIDTH-1];
                        r_z     <= w_zero;
                    end else if (!start) begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        r_acc <= r_op[1] ? w_div : w_mul;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!cancel && !r_z) begin
                        {r_hi, r_lo} <= w_res;
                        r_done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_state != IDLE;
    assign done  = r_done;
    assign stall = busy & (start | rd_hilo | hi_we | lo_we);
endmodule
